dcache_store_drain: RTL

Commit-side store queue sitting directly upstream of the non-blocking L1 data cache's store request port. Buffers committed stores (physical address, data, byte enables) in a small FIFO and drains them in order through the cache's two-phase request protocol: index and request first, tag one cycle after grant. Also reports whether a queued store overlaps a given page offset, so the load path can stall on a possible RAW hazard.

---
 rtl/dcache_store_drain_if.sv | 27 ++
 rtl/dcache_store_drain.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dcache_store_drain_if.sv
// Cache-side store request bus: two-phase (index/request, then tag) handshake
// between the store drain queue (master) and the L1 data cache (slave).
interface dcache_store_drain_if #(
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44
);
  logic                   req;
  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   tag_valid;
  logic                   we;
  logic [7:0]             be;
  logic [1:0]             size;
  logic [63:0]            wdata;
  logic                   kill;
  logic                   gnt;

  modport master (
    output req, index, tag, tag_valid, we, be, size, wdata, kill,
    input  gnt
  );

  modport slave (
    input  req, index, tag, tag_valid, we, be, size, wdata, kill,
    output gnt
  );
endinterface

// File: rtl/dcache_store_drain.sv
// Commit-side store queue: buffers committed stores in a small FIFO and drains
// them in order through the cache's index-then-tag request protocol. Also
// flags queued stores that overlap a load's page offset at doubleword grain.
module dcache_store_drain #(
  parameter int DEPTH       = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clr_i,
  input  logic                             valid_i,
  input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] paddr_i,
  input  logic [63:0]                      data_i,
  input  logic [7:0]                       be_i,
  input  logic [1:0]                       size_i,
  output logic                             ready_o,
  output logic                             empty_o,
  input  logic [INDEX_WIDTH-1:0]           check_off_i,
  output logic                             match_o,
  dcache_store_drain_if.master             bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, TAG} state_e;

  state_e                 state_q, state_d;
  logic [PW:0]            wr_ptr_q, wr_ptr_d;
  logic [PW:0]            rd_ptr_q, rd_ptr_d;

  logic [INDEX_WIDTH-1:0] idx_mem_q  [DEPTH];
  logic [TAG_WIDTH-1:0]   tag_mem_q  [DEPTH];
  logic [63:0]            data_mem_q [DEPTH];
  logic [7:0]             be_mem_q   [DEPTH];
  logic [1:0]             size_mem_q [DEPTH];

  logic [PW-1:0]          head_idx, next_idx;
  logic [PW:0]            cnt;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, second;
  logic [DEPTH-1:0]       entry_vld;

  // Low three offset bits are below doubleword grain and never compared.
  logic                   unused_off;
  assign unused_off = ^check_off_i[2:0];

  assign head_idx   = rd_ptr_q[PW-1:0];
  assign next_idx   = rd_ptr_q[PW-1:0] + 1'b1;
  assign cnt        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                      (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign push       = valid_i && !fifo_full && !clr_i;
  assign pop        = (state_q == TAG);
  // A follow-on request may issue in the tag cycle if another entry is queued
  // or is being pushed right now (forwarded straight from the push inputs).
  assign second     = (cnt >= (PW+1)'(2)) || push;
  assign ready_o    = !fifo_full;
  assign empty_o    = fifo_empty && (state_q == IDLE);

  // Pointer next-state: clear wins, otherwise push and pop advance independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Control state: pointers and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // Entry storage: written on accepted push only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem_q[wr_ptr_q[PW-1:0]]  <= paddr_i[INDEX_WIDTH-1:0];
      tag_mem_q[wr_ptr_q[PW-1:0]]  <= paddr_i[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
      data_mem_q[wr_ptr_q[PW-1:0]] <= data_i;
      be_mem_q[wr_ptr_q[PW-1:0]]   <= be_i;
      size_mem_q[wr_ptr_q[PW-1:0]] <= size_i;
    end
  end

  // Occupancy-based valid mask and doubleword overlap check for the load path.
  always_comb begin
    logic [PW-1:0] rel;
    rel       = '0;
    entry_vld = '0;
    match_o   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel          = PW'(i) - head_idx;
      entry_vld[i] = ({1'b0, rel} < cnt);
      if (entry_vld[i] &&
          (idx_mem_q[i][INDEX_WIDTH-1:3] == check_off_i[INDEX_WIDTH-1:3]))
        match_o = 1'b1;
    end
  end

  // FSM next state and cache bus outputs.
  always_comb begin
    state_d       = state_q;
    bus.req       = 1'b0;
    bus.tag_valid = 1'b0;
    bus.kill      = 1'b0;
    bus.tag       = tag_mem_q[head_idx];
    bus.index     = idx_mem_q[head_idx];
    bus.be        = be_mem_q[head_idx];
    bus.size      = size_mem_q[head_idx];
    bus.wdata     = data_mem_q[head_idx];
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !clr_i) state_d = REQ;
      end
      REQ: begin
        bus.req = 1'b1;
        if (clr_i)        state_d = IDLE;
        else if (bus.gnt) state_d = TAG;
      end
      TAG: begin
        bus.tag_valid = 1'b1;
        bus.kill      = clr_i;
        // Index phase of the following entry overlaps this tag cycle.
        if (cnt >= (PW+1)'(2)) begin
          bus.index = idx_mem_q[next_idx];
          bus.be    = be_mem_q[next_idx];
          bus.size  = size_mem_q[next_idx];
          bus.wdata = data_mem_q[next_idx];
        end else begin
          bus.index = paddr_i[INDEX_WIDTH-1:0];
          bus.be    = be_i;
          bus.size  = size_i;
          bus.wdata = data_i;
        end
        if (clr_i) begin
          state_d = IDLE;
        end else if (second) begin
          bus.req = 1'b1;
          state_d = bus.gnt ? TAG : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    bus.we = bus.req;
  end

endmodule
